// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register: two-entry skid buffer with registered in_ready and a one-cycle PC-redirect pulse.
// Optional performance counters (stall_cnt, redir_cnt) are compiled in when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int WA_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reg_write_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    input  logic              pc_src_i,
    input  logic              br_taken_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic [WA_W-1:0]   wa_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic [WA_W-1:0]   wa_o,
    output logic              redirect,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       redir_cnt,
`endif
    output logic [DATA_W-1:0] redirect_pc
);

    localparam int ENT_W = 4 + 2 * DATA_W + WA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ENT_W-1:0]  main_p1, skid_p1, in_ent;
    logic              acc, deq;
    logic              load_main_in, load_main_skid, load_skid;
    logic              redir_vld_p1;
    logic [DATA_W-1:0] redir_pc_p1;
    logic              redir_set;

    assign in_ent = {reg_write_i, mem_write_i, mem_to_reg_i, pc_src_i,
                     alu_result_i, write_data_i, wa_i};

    // in_ready depends only on the state register, so MEM backpressure never reaches EX combinationally
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;
    assign redir_set = acc & (br_taken_i | pc_src_i) & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && deq) begin
                    load_main_in = 1'b1;
                end else if (acc) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (deq) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (deq) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush drops everything, including an op accepted this same cycle
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Entry storage: MAIN is the head presented to MEM, SKID catches the op that arrives while MAIN stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (load_main_in) begin
                main_p1 <= in_ent;
            end else if (load_main_skid) begin
                main_p1 <= skid_p1;
            end
            if (load_skid) begin
                skid_p1 <= in_ent;
            end
        end
    end

    assign {reg_write_o, mem_write_o, mem_to_reg_o, pc_src_o,
            alu_result_o, write_data_o, wa_o} = main_p1;

    // Redirect stage: pulse follows acceptance regardless of MEM backpressure
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redir_vld_p1 <= 1'b0;
            redir_pc_p1  <= '0;
        end else begin
            redir_vld_p1 <= redir_set;
            if (redir_set) begin
                redir_pc_p1 <= alu_result_i;
            end
        end
    end

    assign redirect    = redir_vld_p1;
    assign redirect_pc = redir_pc_p1;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cnt_p1, redir_cnt_p1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counters survive flush; only reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_p1 <= '0;
            redir_cnt_p1 <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            end
            if (redir_vld_p1) begin
                redir_cnt_p1 <= sat_inc(redir_cnt_p1);
            end
        end
    end

    assign stall_cnt = stall_cnt_p1;
    assign redir_cnt = redir_cnt_p1;
`endif

endmodule
